// File: rtl/ps2_kbd_queue.sv
// ps2_kbd_queue
//
// Keyboard event queue placed between the PS/2 keyboard controller and the
// CPU. A small poll FSM reads the controller's held event (status, code,
// ascii) and acknowledges it. Each event is stored in a FIFO. When the FIFO
// is full the acknowledge is withheld, so the controller keeps holding the
// PS/2 clock low and no event is lost.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   dbr         CPU read data (registered, updated while we=0)
//   dbw         CPU write data
//   addr        CPU register select
//                 0 status {nonempty, full, pend, 0, count}
//                 1 head code
//                 2 head ascii
//                 3 head {rel, ext, shifts}
//   we          CPU write strobe
//                 addr 0 pops one entry
//                 addr 3 with dbw[0] set flushes the FIFO
//   kbd_addr    controller register select
//   kbd_we      controller write strobe (acknowledge)
//   kbd_dbw     controller write data, always zero
//   kbd_dbr     controller read data, one cycle behind kbd_addr

module ps2_kbd_queue #(
    parameter int DEPTH    = 8,
    parameter bit KEEP_REL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] dbr,
    input  logic [7:0] dbw,
    input  logic [1:0] addr,
    input  logic       we,
    output logic [1:0] kbd_addr,
    output logic       kbd_we,
    output logic [7:0] kbd_dbw,
    input  logic [7:0] kbd_dbr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST, CD, AS, AK} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          rel_q;
    logic          ext_q;
    logic [3:0]    shifts_q;
    logic [7:0]    code_q;
    logic          pend;

    // Entry layout: [20] rel, [19] ext, [18:15] shifts, [14:7] code, [6:0] ascii
    logic [20:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [20:0]   head;

    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          flush;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign kbd_dbw = 8'h00;

    // An event is only taken when there is room for it. Otherwise the
    // controller keeps holding it.
    assign accept = (state == CD) && kbd_dbr[7] && !full;
    assign push   = (state == AK) && (KEEP_REL || !rel_q);
    assign pop    = we && (addr == 2'd0) && !empty;
    assign flush  = we && (addr == 2'd3) && dbw[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kbd_addr  = 2'd0;
        kbd_we    = 1'b0;
        case (state)
            ST: begin
                state_nxt = CD;
            end
            CD: begin
                kbd_addr  = 2'd1;
                state_nxt = accept ? AS : ST;
            end
            AS: begin
                kbd_addr  = 2'd2;
                state_nxt = AK;
            end
            AK: begin
                kbd_we    = 1'b1;
                state_nxt = ST;
            end
            default: begin
                state_nxt = ST;
            end
        endcase
    end

    // pend reflects the most recent CD sample: the controller has an event
    // that cannot be accepted because the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q    <= 1'b0;
            ext_q    <= 1'b0;
            shifts_q <= 4'h0;
            code_q   <= 8'h00;
            pend     <= 1'b0;
        end else begin
            if (accept) begin
                rel_q    <= kbd_dbr[6];
                ext_q    <= kbd_dbr[4];
                shifts_q <= kbd_dbr[3:0];
            end
            if (state == AS) begin
                code_q <= kbd_dbr;
            end
            if (state == CD) begin
                pend <= kbd_dbr[7] && full;
            end
        end
    end

    // A push cannot overflow. CD only advances when there is room, and the
    // CPU can only free entries before AK.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {rel_q, ext_q, shifts_q, code_q, kbd_dbr[6:0]};
        end
    end

    // A flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The CPU read port mirrors the controller. It holds during writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbr <= 8'h00;
        end else if (!we) begin
            case (addr)
                2'd0:    dbr <= {!empty, full, pend, 1'b0, 4'(count)};
                2'd1:    dbr <= empty ? 8'h00 : head[14:7];
                2'd2:    dbr <= empty ? 8'h00 : {1'b0, head[6:0]};
                default: dbr <= empty ? 8'h00 : {2'b00, head[20:15]};
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_queue.sv
// tb_ps2_kbd_queue
//
// Directed bench for ps2_kbd_queue. It drives two instances:
//   u_dut   DEPTH=8, KEEP_REL=1
//   u_drop  DEPTH=4, KEEP_REL=0
// Each instance talks to a simple controller model. The model presents queued
// events in order, and each acknowledge advances its head index.

module tb_ps2_kbd_queue;

    logic       clk;
    logic       rst_n;
    logic [7:0] dbr;
    logic [7:0] dbw;
    logic [1:0] addr;
    logic       we;
    logic [1:0] kbd_addr;
    logic       kbd_we;
    logic [7:0] kbd_dbw;
    logic [7:0] kbd_dbr;

    logic [7:0] d_dbr;
    logic [7:0] d_dbw;
    logic [1:0] d_addr;
    logic       d_we;
    logic [1:0] d_kbd_addr;
    logic       d_kbd_we;
    logic [7:0] d_kbd_dbw;
    logic [7:0] d_kbd_dbr;

    logic [7:0] q_st[$];
    logic [7:0] q_cd[$];
    logic [7:0] q_as[$];
    int         ack_cnt;

    logic [7:0] q2_st[$];
    logic [7:0] q2_cd[$];
    logic [7:0] q2_as[$];
    int         ack2_cnt;

    int         checks;
    int         errors;
    int         ack_base;
    logic [7:0] exp8;

    ps2_kbd_queue #(.DEPTH(8), .KEEP_REL(1'b1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dbr      (dbr),
        .dbw      (dbw),
        .addr     (addr),
        .we       (we),
        .kbd_addr (kbd_addr),
        .kbd_we   (kbd_we),
        .kbd_dbw  (kbd_dbw),
        .kbd_dbr  (kbd_dbr)
    );

    ps2_kbd_queue #(.DEPTH(4), .KEEP_REL(1'b0)) u_drop (
        .clk      (clk),
        .rst_n    (rst_n),
        .dbr      (d_dbr),
        .dbw      (d_dbw),
        .addr     (d_addr),
        .we       (d_we),
        .kbd_addr (d_kbd_addr),
        .kbd_we   (d_kbd_we),
        .kbd_dbw  (d_kbd_dbw),
        .kbd_dbr  (d_kbd_dbr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model for u_dut: the held event is q[ack_cnt].
    always @(posedge clk) begin
        if (kbd_we) begin
            ack_cnt <= ack_cnt + 1;
        end else begin
            case (kbd_addr)
                2'd0:    kbd_dbr <= (ack_cnt < q_st.size()) ? q_st[ack_cnt] : 8'h00;
                2'd1:    kbd_dbr <= (ack_cnt < q_cd.size()) ? q_cd[ack_cnt] : 8'h00;
                2'd2:    kbd_dbr <= (ack_cnt < q_as.size()) ? q_as[ack_cnt] : 8'h00;
                default: kbd_dbr <= 8'h00;
            endcase
        end
    end

    // Controller model for u_drop.
    always @(posedge clk) begin
        if (d_kbd_we) begin
            ack2_cnt <= ack2_cnt + 1;
        end else begin
            case (d_kbd_addr)
                2'd0:    d_kbd_dbr <= (ack2_cnt < q2_st.size()) ? q2_st[ack2_cnt] : 8'h00;
                2'd1:    d_kbd_dbr <= (ack2_cnt < q2_cd.size()) ? q2_cd[ack2_cnt] : 8'h00;
                2'd2:    d_kbd_dbr <= (ack2_cnt < q2_as.size()) ? q2_as[ack2_cnt] : 8'h00;
                default: d_kbd_dbr <= 8'h00;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One CPU bus cycle. It returns 1 time unit after the clock edge, so dbr
    // already holds the result of a read.
    task automatic applyStimulus(input logic [1:0] a, input logic w, input logic [7:0] d);
        addr = a;
        we   = w;
        dbw  = d;
        @(posedge clk);
        #1;
        we   = 1'b0;
        dbw  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(2'd0, 1'b0, 8'h00);
        end
    endtask

    task automatic loadEvent(input logic [7:0] st, input logic [7:0] cd, input logic [7:0] as_);
        q_st.push_back(st);
        q_cd.push_back(cd);
        q_as.push_back(as_);
    endtask

    // Bounded wait for a given controller-port state.
    task automatic waitPort(input string tag, input logic [1:0] want_addr, input logic want_we);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            if (kbd_addr == want_addr && kbd_we == want_we) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ack_cnt  = 0;
        ack2_cnt = 0;
        rst_n    = 1'b0;
        addr     = 2'd0;
        we       = 1'b0;
        dbw      = 8'h00;
        d_addr   = 2'd0;
        d_we     = 1'b0;
        d_dbw    = 8'h00;

        $display("[TB] reset state");
        loadEvent(8'h80, 8'h1C, 8'h61);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset dbr", 32'(dbr), 32'h00);
        checkOutput("reset kbd_we", 32'(kbd_we), 32'h0);
        checkOutput("reset kbd_addr", 32'(kbd_addr), 32'h0);
        checkOutput("reset kbd_dbw", 32'(kbd_dbw), 32'h00);

        $display("[TB] single event");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("cd addr", 32'(kbd_addr), 32'd1);
        @(posedge clk); #1;
        checkOutput("as addr", 32'(kbd_addr), 32'd2);
        checkOutput("as no ack", 32'(kbd_we), 32'd0);
        @(posedge clk); #1;
        checkOutput("ak ack", 32'(kbd_we), 32'd1);
        idle(2);
        checkOutput("one reg0", 32'(dbr), 32'h81);
        applyStimulus(2'd1, 1'b0, 8'h00);
        checkOutput("one reg1", 32'(dbr), 32'h1C);
        applyStimulus(2'd2, 1'b0, 8'h00);
        checkOutput("one reg2", 32'(dbr), 32'h61);
        applyStimulus(2'd3, 1'b0, 8'h00);
        checkOutput("one reg3", 32'(dbr), 32'h00);
        checkOutput("one ack count", 32'(ack_cnt), 32'd1);
        applyStimulus(2'd0, 1'b1, 8'h00);
        applyStimulus(2'd0, 1'b0, 8'h00);
        checkOutput("after pop reg0", 32'(dbr), 32'h00);
        applyStimulus(2'd1, 1'b0, 8'h00);
        checkOutput("empty reg1", 32'(dbr), 32'h00);

        $display("[TB] fill to full");
        ack_base = ack_cnt;
        for (int i = 0; i < 9; i++) begin
            loadEvent(8'h80 | 8'(i), 8'h20 + 8'(i), 8'h40 + 8'(i));
        end
        idle(50);
        checkOutput("full reg0 pend", 32'(dbr), 32'hE8);
        checkOutput("full acks", 32'(ack_cnt - ack_base), 32'd8);
        applyStimulus(2'd0, 1'b1, 8'h00);
        idle(8);
        checkOutput("ninth acked", 32'(ack_cnt - ack_base), 32'd9);
        checkOutput("refull reg0", 32'(dbr), 32'hC8);
        for (int i = 1; i < 9; i++) begin
            applyStimulus(2'd1, 1'b0, 8'h00);
            exp8 = 8'h20 + 8'(i);
            checkOutput("drain code", 32'(dbr), 32'(exp8));
            applyStimulus(2'd3, 1'b0, 8'h00);
            exp8 = 8'(i);
            checkOutput("drain shifts", 32'(dbr), 32'(exp8));
            applyStimulus(2'd0, 1'b1, 8'h00);
        end
        applyStimulus(2'd0, 1'b0, 8'h00);
        checkOutput("drained reg0", 32'(dbr), 32'h00);

        $display("[TB] release events");
        loadEvent(8'hC0, 8'h1C, 8'h61);
        q2_st.push_back(8'hC0);
        q2_cd.push_back(8'h1C);
        q2_as.push_back(8'h61);
        idle(8);
        checkOutput("rel reg0", 32'(dbr), 32'h81);
        applyStimulus(2'd3, 1'b0, 8'h00);
        checkOutput("rel reg3", 32'(dbr), 32'h20);
        checkOutput("drop acked", 32'(ack2_cnt), 32'd1);
        checkOutput("drop reg0", 32'(d_dbr), 32'h00);
        applyStimulus(2'd0, 1'b1, 8'h00);
        q2_st.push_back(8'h80);
        q2_cd.push_back(8'h1C);
        q2_as.push_back(8'h61);
        idle(8);
        checkOutput("drop press reg0", 32'(d_dbr), 32'h81);
        checkOutput("drop press acked", 32'(ack2_cnt), 32'd2);

        $display("[TB] pop and flush on AK");
        loadEvent(8'h80, 8'h11, 8'h21);
        loadEvent(8'h90, 8'h12, 8'h22);
        loadEvent(8'h81, 8'h13, 8'h23);
        idle(20);
        checkOutput("three reg0", 32'(dbr), 32'h83);
        loadEvent(8'h82, 8'h14, 8'h24);
        waitPort("wait ak pop", 2'd0, 1'b1);
        applyStimulus(2'd0, 1'b1, 8'h00);
        applyStimulus(2'd0, 1'b0, 8'h00);
        checkOutput("push+pop reg0", 32'(dbr), 32'h83);
        applyStimulus(2'd1, 1'b0, 8'h00);
        checkOutput("push+pop head", 32'(dbr), 32'h12);
        applyStimulus(2'd3, 1'b0, 8'h00);
        checkOutput("ext reg3", 32'(dbr), 32'h10);
        ack_base = ack_cnt;
        loadEvent(8'h80, 8'h15, 8'h25);
        waitPort("wait ak flush", 2'd0, 1'b1);
        applyStimulus(2'd3, 1'b1, 8'h01);
        applyStimulus(2'd0, 1'b0, 8'h00);
        checkOutput("flush reg0", 32'(dbr), 32'h00);
        checkOutput("flush acked", 32'(ack_cnt - ack_base), 32'd1);

        $display("[TB] pop empty");
        applyStimulus(2'd0, 1'b1, 8'h00);
        applyStimulus(2'd0, 1'b0, 8'h00);
        checkOutput("pop empty reg0", 32'(dbr), 32'h00);
        loadEvent(8'h85, 8'h2A, 8'h3B);
        idle(8);
        applyStimulus(2'd1, 1'b0, 8'h00);
        checkOutput("after empty code", 32'(dbr), 32'h2A);
        applyStimulus(2'd2, 1'b0, 8'h00);
        checkOutput("after empty ascii", 32'(dbr), 32'h3B);
        applyStimulus(2'd3, 1'b0, 8'h00);
        checkOutput("after empty reg3", 32'(dbr), 32'h05);
        applyStimulus(2'd0, 1'b1, 8'h00);

        $display("[TB] reset during AS");
        ack_base = ack_cnt;
        loadEvent(8'h80, 8'h33, 8'h44);
        waitPort("wait as", 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst kbd_addr", 32'(kbd_addr), 32'd0);
        checkOutput("rst kbd_we", 32'(kbd_we), 32'd0);
        checkOutput("rst dbr", 32'(dbr), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst no ack", 32'(ack_cnt - ack_base), 32'd0);
        rst_n = 1'b1;
        idle(10);
        checkOutput("reread acked once", 32'(ack_cnt - ack_base), 32'd1);
        checkOutput("reread reg0", 32'(dbr), 32'h81);
        applyStimulus(2'd1, 1'b0, 8'h00);
        checkOutput("reread code", 32'(dbr), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_queue.md
# ps2_kbd_queue

Keyboard event queue sitting directly downstream of the PS/2 keyboard controller. It polls the controller's register port autonomously, reads each held key event (status, scan code, ASCII), acknowledges it to release the PS/2 clock, and stores it in a small FIFO. The CPU reads buffered events through a 4-register bus slave instead of racing the controller. When the FIFO is full, the block withholds the acknowledge, so the keyboard is throttled by PS/2 clock inhibit and no event is ever lost.

## Interface
- `DEPTH`, 8: FIFO entries. Power of two, 2..8.
- `KEEP_REL`, 1: 1 = queue release events; 0 = acknowledge release events and drop them.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `dbr`  out  8  CPU data bus read (registered)
- `dbw`  in  8  CPU data bus write
- `addr`  in  2  CPU register select
- `we`  in  1  CPU write strobe
- `kbd_addr`  out  2  controller register select
- `kbd_we`  out  1  controller write strobe; a write acknowledges the held event
- `kbd_dbw`  out  8  controller write data; always 0
- `kbd_dbr`  in  8  controller read data; updated on every clk edge where `kbd_we`=0, from the `kbd_addr` driven in that cycle
  - addr 0: {valid, release, parity, extended, shifts[3:0]}
  - addr 1: code
  - addr 2: {0, ascii[6:0]}

## Operation
- Reset: all outputs 0, FSM in ST, FIFO empty, count 0.
- Poll FSM. Outputs are a function of state only.
  - **ST**: drive `kbd_addr`=0 → CD.
  - **CD**: drive `kbd_addr`=1. Sample `kbd_dbr` as status.
    - If status[7]=1 and FIFO not full: latch rel=bit6, ext=bit4, shifts=bits3:0 → AS.
    - Otherwise → ST.
  - **AS**: drive `kbd_addr`=2. Sample `kbd_dbr` as code → AK.
  - **AK**: drive `kbd_we`=1. Sample `kbd_dbr[6:0]` as ascii.
    - Push {rel, ext, shifts, code, ascii} (21 bits) unless KEEP_REL=0 and rel=1.
    - → ST.
- `pend` (status bit 5) is set when CD samples valid=1 with FIFO full. It clears when CD samples valid=0 or takes an event.
- CPU registers. `dbr` updates on clk when `we`=0, like the controller.
  - 0: {nonempty, full, pend, 0, count[3:0]}
  - 1: head code
  - 2: {0, head ascii}
  - 3: {0, 0, head rel, head ext, head shifts}
  - With the FIFO empty, regs 1–3 read 0.
- CPU writes:
  - Write to addr 0, any data: pop one entry. Ignored when empty.
  - Write to addr 3 with `dbw[0]`=1: flush (pointers and count to 0).
  - Writes to addr 1 and 2 are ignored.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, saturating at DEPTH by construction.

## Timing
- Poll period when idle: 2 cycles (ST, CD).
- Event accept: 4 cycles, ST→CD→AS→AK.
- Pushed entry is visible in a CPU reg-0 read issued the cycle after AK (`dbr` valid one more cycle later).
- Same-cycle push and pop:
  - Non-empty: both occur, count unchanged.
  - Empty: push only, and the pop is ignored.
- Same-cycle flush and push: flush wins and the entry is discarded. The event is still acknowledged.
- Same-cycle flush and pop: flush.
- Full: CD never advances, so the controller keeps `rx_hold` and holds PS/2 clock low. One pop lets the next CD accept.
- `rst_n` asserted mid-sequence (including during AK): FSM returns to ST and `kbd_we` drops immediately. A held event is re-read after reset.
- Polling continues regardless of CPU access. The two sides share only FIFO state.

## Test plan
- Reset, then controller model presents status 0x80, code 0x1C, ascii 0x61 → exactly one `kbd_we` pulse 3 cycles after first CD; reg0 reads 0x81, reg1 0x1C, reg2 0x61, reg3 0x00. Write reg0 → reg0 reads 0x00.
- Nine events with DEPTH=8 and no pops → count 8, reg0 0xC8. Ninth event: no `kbd_we`, pend=1 (reg0 0xE8). One pop → ninth acknowledged within 4 cycles, reg0 0xC8, FIFO order preserved across pointer wrap.
- KEEP_REL=0, status 0xC0 code 0x1C → `kbd_we` pulses, count stays 0. KEEP_REL=1, same input → reg3 reads 0x20.
- Pop on the AK cycle with FIFO holding 3 → count stays 3. Flush on an AK cycle → count 0, `kbd_we` still pulses.
- Pop with FIFO empty → count 0, pointers unchanged. Next push reads back correctly.
- `rst_n` low during AS → outputs 0, FSM ST. The held event is re-read and acknowledged exactly once after release.
